load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 157 +++++++++++++++
 tb/tb_load_store_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit for the memory stage: formats byte/half/word accesses onto a
// word-wide request/ack memory port, stalls the pipeline and aborts on timeout.
module load_store_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            Funct3M,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallM,
  output logic                  ErrorM
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                  state, state_next;
  logic [CW-1:0]           cnt;
  logic [1:0]              off_q;
  logic [2:0]              f3_q;
  logic                    we_q;

  logic                    is_req, legal, aligned, valid;
  logic                    timed_out;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [3:0]              req_wstrb;
  logic [DATA_WIDTH-1:0]   shifted;
  logic [DATA_WIDTH-1:0]   load_data;

  // Access decode; a simultaneous read+write request is handled as a store.
  always_comb begin
    is_req = MemReadM | MemWriteM;
    if (MemWriteM) legal = (Funct3M == 3'b000) || (Funct3M == 3'b001) || (Funct3M == 3'b010);
    else           legal = (Funct3M[1:0] != 2'b11) && !(Funct3M[2] && Funct3M[1]);
    case (Funct3M[1:0])
      2'b01:   aligned = (ALUResultM[0] == 1'b0);
      2'b10:   aligned = (ALUResultM[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    valid = is_req && legal && aligned;
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    req_wdata = WriteDataM;
    req_wstrb = 4'b0000;
    if (MemWriteM) begin
      case (Funct3M[1:0])
        2'b00: begin
          req_wdata = {(DATA_WIDTH/8){WriteDataM[7:0]}};
          req_wstrb = 4'b0001 << ALUResultM[1:0];
        end
        2'b01: begin
          req_wdata = {(DATA_WIDTH/16){WriteDataM[15:0]}};
          req_wstrb = 4'b0011 << ALUResultM[1:0];
        end
        default: req_wstrb = 4'b1111;
      endcase
    end
  end

  // Load formatting from the offset and size captured when the request issued.
  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  // An ack on the final counted cycle wins over the timeout.
  assign timed_out = (state == WAIT) && !mem_ack && (cnt == CW'(TIMEOUT_CYCLES));

  always_comb begin
    state_next = state;
    StallM     = 1'b0;
    case (state)
      IDLE: begin
        StallM = valid;
        if (valid) state_next = WAIT;
      end
      WAIT: begin
        StallM = 1'b1;
        if (mem_ack || timed_out) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: asynchronous reset in the sensitivity list; registers use non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      off_q     <= 2'b00;
      f3_q      <= 3'b000;
      we_q      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= 4'b0000;
      ReadDataM <= '0;
      ErrorM    <= 1'b0;
    end else begin
      state  <= state_next;
      ErrorM <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            cnt       <= CW'(1);
            off_q     <= ALUResultM[1:0];
            f3_q      <= Funct3M;
            we_q      <= MemWriteM;
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM;
            mem_addr  <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
            mem_wdata <= req_wdata;
            mem_wstrb <= req_wstrb;
          end else if (is_req) begin
            ErrorM <= 1'b1;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!we_q) ReadDataM <= load_data;
          end else if (timed_out) begin
            mem_req <= 1'b0;
            ErrorM  <= 1'b1;
            if (!we_q) ReadDataM <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected requests and load results are
// queued when stimulus is driven and compared when the DUT presents them.
module tb_load_store_unit;

  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          MemReadM = 1'b0, MemWriteM = 1'b0;
  logic [2:0]    Funct3M = 3'b000;
  logic [DW-1:0] ALUResultM = '0, WriteDataM = '0;
  logic          mem_req, mem_we;
  logic [DW-1:0] mem_addr, mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] ReadDataM;
  logic          StallM, ErrorM;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  req_t        req_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] last_rd = '0;
  int          n_vec = 0;
  int          n_err = 0;

  load_store_unit #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ReadDataM(ReadDataM), .StallM(StallM), .ErrorM(ErrorM)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
  endtask

  function automatic logic [3:0] exp_wstrb(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000:  case (off) 2'd0: return 4'b0001; 2'd1: return 4'b0010;
                          2'd2: return 4'b0100; default: return 4'b1000; endcase
      3'b001:  return (off == 2'd0) ? 4'b0011 : 4'b1100;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [7:0]  b;
    logic [15:0] h;
    b = wd[7:0];
    h = wd[15:0];
    case (f3)
      3'b000:  return {b, b, b, b};
      3'b001:  return {h, h};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return b[7] ? (32'hFFFF_FF00 | {24'h0, b}) : {24'h0, b};
      3'b001:  return h[15] ? (32'hFFFF_0000 | {16'h0, h}) : {16'h0, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // Full valid access: issue, hold for delay WAIT cycles with ack on the last, check DONE.
  task automatic do_access(input string nm, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rdat, input int delay);
    req_t        e;
    req_t        got;
    logic [31:0] er;
    int          stalls;
    e.addr  = {addr[31:2], 2'b00};
    e.we    = wr;
    e.wdata = exp_wdata(f3, wd);
    e.wstrb = wr ? exp_wstrb(f3, addr[1:0]) : 4'b0000;
    req_q.push_back(e);
    rd_q.push_back(wr ? last_rd : exp_load(f3, addr[1:0], rdat));
    stalls = 0;
    drive(rd, wr, f3, addr, wd);
    #1;
    if (StallM === 1'b1) stalls++;
    step();
    got = req_q.pop_front();
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL %s mem_req got %0b want 1", nm, mem_req); end
    n_vec++; if (mem_addr !== got.addr) begin n_err++; $display("FAIL %s mem_addr got %h want %h", nm, mem_addr, got.addr); end
    n_vec++; if (mem_we !== got.we) begin n_err++; $display("FAIL %s mem_we got %0b want %0b", nm, mem_we, got.we); end
    n_vec++; if (mem_wstrb !== got.wstrb) begin n_err++; $display("FAIL %s mem_wstrb got %b want %b", nm, mem_wstrb, got.wstrb); end
    if (got.we) begin
      n_vec++; if (mem_wdata !== got.wdata) begin n_err++; $display("FAIL %s mem_wdata got %h want %h", nm, mem_wdata, got.wdata); end
    end
    for (int w = 1; w <= delay; w++) begin
      if (w == delay) begin mem_ack = 1'b1; mem_rdata = rdat; end
      else mem_rdata = $urandom;
      #1;
      if (StallM === 1'b1) stalls++;
      if (w > 1) begin
        n_vec++;
        if (mem_req !== 1'b1 || mem_addr !== got.addr || mem_wstrb !== got.wstrb) begin
          n_err++; $display("FAIL %s hold w%0d req/addr got %0b/%h want 1/%h", nm, w, mem_req, mem_addr, got.addr);
        end
      end
      step();
      mem_ack = 1'b0;
    end
    er = rd_q.pop_front();
    n_vec++; if (StallM !== 1'b0) begin n_err++; $display("FAIL %s done StallM got %0b want 0", nm, StallM); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL %s done mem_req got %0b want 0", nm, mem_req); end
    n_vec++; if (ReadDataM !== er) begin n_err++; $display("FAIL %s ReadDataM got %h want %h", nm, ReadDataM, er); end
    n_vec++; if (ErrorM !== 1'b0) begin n_err++; $display("FAIL %s ErrorM got %0b want 0", nm, ErrorM); end
    n_vec++; if (stalls != delay + 1) begin n_err++; $display("FAIL %s stall cycles got %0d want %0d", nm, stalls, delay + 1); end
    last_rd = er;
    drive(1'b0, 1'b0, 3'b000, '0, '0);
    step();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
        mem_wstrb !== 4'b0 || ReadDataM !== '0 || ErrorM !== 1'b0 || StallM !== 1'b0) begin
      n_err++; $display("FAIL reset outputs got req=%0b addr=%h rd=%h err=%0b want all zero", mem_req, mem_addr, ReadDataM, ErrorM);
    end
    step();
    #2 rst_n = 1'b1;
    step();
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_release mem_req got %0b want 0", mem_req); end
  endtask

  task automatic test_lb();
    do_access("lb_103", 1'b1, 1'b0, 3'b000, 32'h0000_0103, '0, 32'h80FF_1234, 2);
  endtask

  task automatic test_half();
    do_access("lhu_102", 1'b1, 1'b0, 3'b101, 32'h0000_0102, '0, 32'h8001_0000, 1);
    do_access("lh_102",  1'b1, 1'b0, 3'b001, 32'h0000_0102, '0, 32'h8001_0000, 3);
  endtask

  task automatic test_store();
    do_access("sb_201", 1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h1234_56AB, 32'hDEAD_BEEF, 1);
    do_access("sh_rw_206", 1'b1, 1'b1, 3'b001, 32'h0000_0206, 32'h0000_C3A5, 32'h0, 2);
    do_access("sw_300", 1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 32'h0, 1);
  endtask

  task automatic one_invalid(input string nm, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] addr);
    drive(rd, wr, f3, addr, 32'h5555_AAAA);
    #1;
    n_vec++; if (StallM !== 1'b0) begin n_err++; $display("FAIL %s StallM got %0b want 0", nm, StallM); end
    step();
    drive(1'b0, 1'b0, 3'b000, '0, '0);
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL %s mem_req got %0b want 0", nm, mem_req); end
    n_vec++; if (ErrorM !== 1'b1) begin n_err++; $display("FAIL %s ErrorM got %0b want 1", nm, ErrorM); end
    n_vec++; if (ReadDataM !== last_rd) begin n_err++; $display("FAIL %s ReadDataM got %h want %h", nm, ReadDataM, last_rd); end
    step();
    n_vec++; if (ErrorM !== 1'b0) begin n_err++; $display("FAIL %s ErrorM pulse got %0b want 0", nm, ErrorM); end
  endtask

  task automatic test_invalid();
    one_invalid("lw_misalign", 1'b1, 1'b0, 3'b010, 32'h0000_0102);
    one_invalid("ld_f3_011",   1'b1, 1'b0, 3'b011, 32'h0000_0100);
    one_invalid("lh_odd",      1'b1, 1'b0, 3'b001, 32'h0000_0101);
    one_invalid("sbu_100",     1'b0, 1'b1, 3'b100, 32'h0000_0100);
  endtask

  task automatic test_timeout();
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0400, '0);
    step();
    for (int w = 1; w <= TO; w++) begin
      n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL timeout wait%0d mem_req got %0b want 1", w, mem_req); end
      step();
    end
    drive(1'b0, 1'b0, 3'b000, '0, '0);
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL timeout mem_req got %0b want 0", mem_req); end
    n_vec++; if (ErrorM !== 1'b1) begin n_err++; $display("FAIL timeout ErrorM got %0b want 1", ErrorM); end
    n_vec++; if (ReadDataM !== 32'h0) begin n_err++; $display("FAIL timeout ReadDataM got %h want 0", ReadDataM); end
    n_vec++; if (StallM !== 1'b0) begin n_err++; $display("FAIL timeout StallM got %0b want 0", StallM); end
    last_rd = '0;
    step();
    n_vec++; if (ErrorM !== 1'b0) begin n_err++; $display("FAIL timeout_idle ErrorM got %0b want 0", ErrorM); end
    // Ack arriving on the last counted cycle is a success.
    do_access("lw_ack_at_to", 1'b1, 1'b0, 3'b010, 32'h0000_0404, '0, 32'h1357_9BDF, TO);
  endtask

  task automatic test_stray_ack();
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_ack = 1'b0;
    n_vec++;
    if (mem_req !== 1'b0 || ReadDataM !== last_rd || ErrorM !== 1'b0) begin
      n_err++; $display("FAIL stray_ack req/rd/err got %0b/%h/%0b want 0/%h/0", mem_req, ReadDataM, ErrorM, last_rd);
    end
  endtask

  task automatic test_reset_in_wait();
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0500, '0);
    step();
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rst_wait issue mem_req got %0b want 1", mem_req); end
    drive(1'b0, 1'b0, 3'b000, '0, '0);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (mem_req !== 1'b0 || mem_addr !== '0 || mem_wstrb !== 4'b0 || ReadDataM !== '0 || StallM !== 1'b0) begin
      n_err++; $display("FAIL rst_wait async got req=%0b addr=%h rd=%h stall=%0b want zeros", mem_req, mem_addr, ReadDataM, StallM);
    end
    #2 rst_n = 1'b1;
    last_rd = '0;
    step();
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    step();
    mem_ack = 1'b0;
    n_vec++;
    if (mem_req !== 1'b0 || ReadDataM !== '0 || ErrorM !== 1'b0 || StallM !== 1'b0) begin
      n_err++; $display("FAIL rst_wait ack got req=%0b rd=%h err=%0b stall=%0b want 0/0/0/0", mem_req, ReadDataM, ErrorM, StallM);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] f3s [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000, 3'b001, 3'b010};
    for (int i = 0; i < 12; i++) begin
      int          k;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] a;
      k  = $urandom_range(0, 7);
      f3 = f3s[k];
      wr = (k >= 5);
      a  = 32'h0000_1000 + ($urandom_range(0, 63) << 2);
      if (f3[1:0] == 2'b00) a[1:0] = 2'($urandom_range(0, 3));
      else if (f3[1:0] == 2'b01) a[1] = 1'($urandom_range(0, 1));
      do_access($sformatf("b2b_%0d", i), wr ? 1'($urandom_range(0, 1)) : 1'b1, wr, f3, a,
                $urandom, $urandom, $urandom_range(1, TO));
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_half();
    test_store();
    test_invalid();
    test_timeout();
    test_stray_ack();
    test_reset_in_wait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
